// File: rtl/mpc_rsp_rob.sv
// mpc_rsp_rob: per-channel response reorder buffer for the multi-port cache
// return path.
//
// The channel allocates a rob_id per load in issue order. Banks return
// beats out of order, tagged {channel_id, rob_id}. Beats for other channels
// are dropped. Beats for this channel are stored in their slots. Data is
// returned to the channel strictly in allocation order.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   alloc_valid_i/ready_o allocation handshake; alloc_id_o = granted rob_id
//   bank_rsp_valid_i      bank beat present (no backpressure)
//   bank_rsp_i            {channel_id[1:0], rob_id[2:0], rdata[127:0]}
//   ch_rsp_valid_o/ready_i in-order response handshake; ch_rsp_o = rdata
//   count_o               allocated entries (PENDING + DONE)
//   err_o                 one-cycle pulse for a beat hitting a FREE/DONE slot
module mpc_rsp_rob #(
    parameter int unsigned ROB_SIZE   = 8,
    parameter int unsigned ROB_WIDTH  = $clog2(ROB_SIZE),
    parameter int unsigned DATA_WIDTH = 128,
    parameter logic [1:0]  CHANNEL_ID = 2'd0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  alloc_valid_i,
    output logic                  alloc_ready_o,
    output logic [ROB_WIDTH-1:0]  alloc_id_o,
    input  logic                  bank_rsp_valid_i,
    input  logic [132:0]          bank_rsp_i,
    output logic                  ch_rsp_valid_o,
    input  logic                  ch_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] ch_rsp_o,
    output logic [ROB_WIDTH:0]    count_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        DONE    = 2'd2
    } entry_state_t;

    entry_state_t          st     [ROB_SIZE];
    entry_state_t          st_n   [ROB_SIZE];
    logic [DATA_WIDTH-1:0] data   [ROB_SIZE];
    logic [DATA_WIDTH-1:0] data_n [ROB_SIZE];

    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;
    logic                 err;
    logic                 err_n;

    logic [1:0]            bank_ch;
    logic [2:0]            bank_id;
    logic [DATA_WIDTH-1:0] bank_data;
    logic [ROB_WIDTH-1:0]  bank_idx;
    logic                  bank_ours;
    logic                  bank_in_range;

    logic alloc_fire;
    logic out_fire;

    assign bank_ch       = bank_rsp_i[132:131];
    assign bank_id       = bank_rsp_i[130:128];
    assign bank_data     = bank_rsp_i[DATA_WIDTH-1:0];
    assign bank_idx      = bank_id[ROB_WIDTH-1:0];
    assign bank_ours     = bank_rsp_valid_i && (bank_ch == CHANNEL_ID);
    assign bank_in_range = (32'(bank_id) < ROB_SIZE);

    // Ready comes from the registered count only, so a full buffer stays
    // closed for the cycle in which the head drains.
    assign alloc_ready_o  = (count < (ROB_WIDTH+1)'(ROB_SIZE));
    assign alloc_id_o     = tail;
    assign ch_rsp_valid_o = (st[head] == DONE);
    assign ch_rsp_o       = data[head];
    assign count_o        = count;
    assign err_o          = err;

    assign alloc_fire = alloc_valid_i && alloc_ready_o;
    assign out_fire   = ch_rsp_valid_o && ch_rsp_ready_i;

    // The bank lookup uses the registered state, so a beat for the slot
    // being allocated this cycle sees FREE and is flagged as an error.
    always_comb begin
        st_n   = st;
        data_n = data;
        err_n  = 1'b0;
        if (bank_ours) begin
            if (bank_in_range && st[bank_idx] == PENDING) begin
                st_n[bank_idx]   = DONE;
                data_n[bank_idx] = bank_data;
            end else begin
                err_n = 1'b1;
            end
        end
        if (out_fire) begin
            st_n[head] = FREE;
        end
        if (alloc_fire) begin
            st_n[tail] = PENDING;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                st[i]   <= FREE;
                data[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                st[i]   <= st_n[i];
                data[i] <= data_n[i];
            end
            err <= err_n;
            if (alloc_fire) begin
                tail <= tail + ROB_WIDTH'(1);
            end
            if (out_fire) begin
                head <= head + ROB_WIDTH'(1);
            end
            case ({alloc_fire, out_fire})
                2'b10:   count <= count + (ROB_WIDTH+1)'(1);
                2'b01:   count <= count - (ROB_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mpc_rsp_rob.sv
// tb_mpc_rsp_rob: directed self-checking bench for mpc_rsp_rob.
// Inputs change 1 time unit after the rising edge; outputs are checked in
// the same window, before the next rising edge.
module tb_mpc_rsp_rob;

    logic         clk;
    logic         rst;
    logic         alloc_valid;
    logic         alloc_ready;
    logic [2:0]   alloc_id;
    logic         bank_valid;
    logic [1:0]   bank_ch;
    logic [2:0]   bank_id;
    logic [127:0] bank_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic [3:0]   count;
    logic         err;

    int errors = 0;
    int checks = 0;

    mpc_rsp_rob #(
        .ROB_SIZE  (8),
        .DATA_WIDTH(128),
        .CHANNEL_ID(2'd0)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .alloc_valid_i   (alloc_valid),
        .alloc_ready_o   (alloc_ready),
        .alloc_id_o      (alloc_id),
        .bank_rsp_valid_i(bank_valid),
        .bank_rsp_i      ({bank_ch, bank_id, bank_data}),
        .ch_rsp_valid_o  (rsp_valid),
        .ch_rsp_ready_i  (rsp_ready),
        .ch_rsp_o        (rsp_data),
        .count_o         (count),
        .err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] ch, input logic [2:0] id,
                        input logic [127:0] d);
        bank_valid = 1'b1;
        bank_ch    = ch;
        bank_id    = id;
        bank_data  = d;
    endtask

    task automatic no_beat();
        bank_valid = 1'b0;
        bank_ch    = 2'd0;
        bank_id    = 3'd0;
        bank_data  = '0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        alloc_valid = 1'b0;
        rsp_ready   = 1'b0;
        no_beat();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Allocate n consecutive ids, checking each granted id.
    task automatic alloc_n(input int n, input logic [2:0] first);
        logic [2:0] id;
        id = first;
        alloc_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            check("alloc_id", 128'(alloc_id), 128'(id));
            tick();
            id = id + 3'd1;
        end
        alloc_valid = 1'b0;
    endtask

    initial begin
        logic [2:0]   ida;
        logic [2:0]   idb;
        logic [127:0] da;
        logic [127:0] db;

        do_reset();
        check("rst_valid", 128'(rsp_valid), 128'(0));
        check("rst_ready", 128'(alloc_ready), 128'(1));
        check("rst_count", 128'(count), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_id", 128'(alloc_id), 128'(0));
        check("rst_data", rsp_data, 128'(0));

        // In order, ready held high.
        rsp_ready = 1'b1;
        alloc_n(3, 3'd0);
        check("io_count3", 128'(count), 128'(3));
        beat(2'd0, 3'd0, 128'hA0);
        tick();
        check("io_v0", 128'(rsp_valid), 128'(1));
        check("io_d0", rsp_data, 128'hA0);
        beat(2'd0, 3'd1, 128'hA1);
        tick();
        check("io_v1", 128'(rsp_valid), 128'(1));
        check("io_d1", rsp_data, 128'hA1);
        beat(2'd0, 3'd2, 128'hA2);
        tick();
        check("io_v2", 128'(rsp_valid), 128'(1));
        check("io_d2", rsp_data, 128'hA2);
        no_beat();
        tick();
        check("io_vend", 128'(rsp_valid), 128'(0));
        check("io_count0", 128'(count), 128'(0));

        // Reverse-order return.
        do_reset();
        rsp_ready = 1'b1;
        alloc_n(4, 3'd0);
        for (int i = 3; i >= 1; i--) begin
            beat(2'd0, 3'(i), 128'hD0 + 128'(i));
            tick();
            check("rev_hold", 128'(rsp_valid), 128'(0));
        end
        beat(2'd0, 3'd0, 128'hD0);
        tick();
        no_beat();
        for (int i = 0; i < 4; i++) begin
            check("rev_v", 128'(rsp_valid), 128'(1));
            check("rev_d", rsp_data, 128'hD0 + 128'(i));
            tick();
        end
        check("rev_vend", 128'(rsp_valid), 128'(0));
        check("rev_count", 128'(count), 128'(0));

        // Full buffer, then no-bypass on the draining cycle.
        do_reset();
        alloc_n(8, 3'd0);
        check("full_ready", 128'(alloc_ready), 128'(0));
        check("full_count", 128'(count), 128'(8));
        beat(2'd0, 3'd0, 128'h50);
        tick();
        no_beat();
        alloc_valid = 1'b1;
        rsp_ready   = 1'b1;
        check("full_v", 128'(rsp_valid), 128'(1));
        check("full_nogrant", 128'(alloc_ready), 128'(0));
        tick();
        rsp_ready = 1'b0;
        check("drain_count", 128'(count), 128'(7));
        check("drain_ready", 128'(alloc_ready), 128'(1));
        check("drain_id", 128'(alloc_id), 128'(0));
        tick();
        alloc_valid = 1'b0;
        check("regrant_count", 128'(count), 128'(8));
        check("regrant_tail", 128'(alloc_id), 128'(1));

        // 20 allocations in pairs, each pair returned out of order; ids wrap.
        do_reset();
        for (int r = 0; r < 10; r++) begin
            ida = 3'(2 * r);
            idb = 3'(2 * r + 1);
            da  = 128'h1000 + 128'(2 * r);
            db  = 128'h1000 + 128'(2 * r + 1);
            alloc_n(2, ida);
            beat(2'd0, idb, db);
            tick();
            check("wrap_hold", 128'(rsp_valid), 128'(0));
            beat(2'd0, ida, da);
            tick();
            no_beat();
            rsp_ready = 1'b1;
            check("wrap_da", rsp_data, da);
            tick();
            check("wrap_vb", 128'(rsp_valid), 128'(1));
            check("wrap_db", rsp_data, db);
            tick();
            rsp_ready = 1'b0;
            check("wrap_count", 128'(count), 128'(0));
        end

        // Channel filter.
        do_reset();
        alloc_n(1, 3'd0);
        beat(2'd1, 3'd0, 128'h66);
        tick();
        no_beat();
        check("filt_err", 128'(err), 128'(0));
        check("filt_v", 128'(rsp_valid), 128'(0));
        beat(2'd0, 3'd0, 128'h77);
        tick();
        no_beat();
        check("own_err", 128'(err), 128'(0));
        check("own_v", 128'(rsp_valid), 128'(1));
        check("own_d", rsp_data, 128'h77);

        // Second beat to a DONE slot.
        beat(2'd0, 3'd0, 128'h99);
        tick();
        no_beat();
        check("dup_err", 128'(err), 128'(1));
        check("dup_d", rsp_data, 128'h77);
        tick();
        check("dup_err_end", 128'(err), 128'(0));

        // Beat to a FREE slot.
        beat(2'd0, 3'd3, 128'h33);
        tick();
        no_beat();
        check("free_err", 128'(err), 128'(1));
        check("free_count", 128'(count), 128'(1));
        tick();
        check("free_err_end", 128'(err), 128'(0));

        // Beat for the slot being allocated in the same cycle.
        alloc_valid = 1'b1;
        beat(2'd0, 3'd1, 128'h11);
        tick();
        alloc_valid = 1'b0;
        no_beat();
        check("same_err", 128'(err), 128'(1));
        check("same_count", 128'(count), 128'(2));
        beat(2'd0, 3'd1, 128'h11);
        tick();
        no_beat();
        check("same_late_err", 128'(err), 128'(0));

        // Backpressure: head stays stable.
        for (int i = 0; i < 5; i++) begin
            check("bp_v", 128'(rsp_valid), 128'(1));
            check("bp_d", rsp_data, 128'h77);
            tick();
        end

        // Third DONE entry, then reset with a beat in the reset cycle.
        alloc_n(1, 3'd2);
        beat(2'd0, 3'd2, 128'h22);
        tick();
        check("pre_rst_count", 128'(count), 128'(3));
        rst = 1'b1;
        beat(2'd0, 3'd5, 128'h55);
        tick();
        rst = 1'b0;
        no_beat();
        check("mrst_v", 128'(rsp_valid), 128'(0));
        check("mrst_count", 128'(count), 128'(0));
        check("mrst_id", 128'(alloc_id), 128'(0));
        check("mrst_data", rsp_data, 128'(0));
        tick();
        check("mrst_err", 128'(err), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
